// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_e;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,output logic            ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             cell_d, cell_bout;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = {cell_d, d_sr_q[WIDTH-1:1]};
                brw_d  = cell_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    diff_d  = d_sr_d;
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // On the last bit the cell inputs are the operand MSBs.
                    ovf_d   = (a_sr_q[0] != b_sr_q[0]) && (cell_d != a_sr_q[0]);
`endif
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] prev_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,.ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk(tag, {31'd0, ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; n counts edges with the start-sampling edge as edge 1.
    task automatic wait_done(input string tag, input int start_edge_count);
        int n;
        n = start_edge_count;
        while (!done && n < 20) begin
            tick();
            n++;
            if (busy && done) chk({tag, "_excl"}, 32'd1, 32'd0);
        end
        chk({tag, "_lat"}, n, W + 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input logic [W-1:0] ed, input logic eb, input logic eo);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, {24'd0, diff}, {24'd0, prev_diff});
        wait_done(tag, 1);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk_ovf({tag, "_ovf"}, eo);
        prev_diff = ed;
    endtask

    initial begin
        int nd;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;

        run_op("s05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        tick();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_diff", {24'd0, diff}, 32'h02);
        run_op("s03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("s80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("s7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("s20m0F", 8'h20, 8'h0F, 1'b1, 8'h10, 1'b0, 1'b0);
        run_op("s00mFF", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("s00m00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Back-to-back: start held during the DONE cycle.
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done", {31'd0, done}, 32'd0);
        wait_done("b2b", 1);
        chk("b2b_diff", {24'd0, diff}, 32'h0F);
        chk("b2b_bout", {31'd0, bout}, 32'd0);
        prev_diff = 8'h0F;
        tick();

        // Mid-RUN start pulse and operand changes are ignored.
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_hold", {24'd0, diff}, 32'h0F);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        wait_done("mid", 4);
        chk("mid_diff", {24'd0, diff}, 32'h1E);
        chk("mid_bout", {31'd0, bout}, 32'd0);
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        chk("mid_nodone", nd, 0);

        // Reset asserted while processing bit 4.
        a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_diff", {24'd0, diff}, 32'd0);
        chk("rr_bout", {31'd0, bout}, 32'd0);
        chk("rr_done", {31'd0, done}, 32'd0);
        chk_ovf("rr_ovf", 1'b0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            tick();
            if (done || busy) nd++;
        end
        chk("rr_nodone", nd, 0);
        prev_diff = 8'h00;
        run_op("s77m11", 8'h77, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, operand/result bit count (legal range 2..32).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port start SHALL be: start  input  1  request; sampled only when not busy.
REQ-005 Port a SHALL be: a  input  WIDTH  minuend, captured on accepted start.
REQ-006 Port b SHALL be: b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 Port bin SHALL be: bin  input  1  initial borrow-in, captured on accepted start.
REQ-008 Port busy SHALL be: busy  output  1  high while a subtraction is in progress.
REQ-009 Port done SHALL be: done  output  1  single-cycle completion pulse.
REQ-010 Port diff SHALL be: diff  output  WIDTH  result a-b-bin modulo 2^WIDTH.
REQ-011 Port bout SHALL be: bout  output  1  final borrow-out (1 when a < b+bin, unsigned).
REQ-012 Port ovf SHALL be: ovf  output  1  signed overflow; present only under REQ-027.

Function
REQ-013 FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and bin, clear the bit counter, and enter RUN.
REQ-015 RUN SHALL process one bit per cycle, LSB first, using diff_i = a_i^b_i^brw and brw' = (~a_i&b_i)|(~(a_i^b_i)&brw).
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 SHALL enter DONE.
REQ-017 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unless start=1 (REQ-014).
REQ-018 Latency: done SHALL rise WIDTH+1 edges after the edge that sampled start.
REQ-019 busy SHALL be 1 exactly while in RUN; busy and done SHALL never both be 1.
REQ-020 start while in RUN SHALL be ignored; a, b and bin changes after capture SHALL have no effect.
REQ-021 diff and bout SHALL update only on the edge entering DONE and SHALL hold until the next DONE entry.
REQ-022 Back-to-back: start=1 during DONE SHALL begin the next operation with no IDLE cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0 and ovf=0, including mid-RUN.
REQ-024 An operation interrupted by reset SHALL be abandoned, with no done pulse after release.
REQ-025 After rst_n deassertion, the first start SHALL be accepted on the first rising edge at which it is sampled.

Configuration
REQ-026 The macro SERIAL_SUB_OVERFLOW_EN SHALL gate the overflow feature.
REQ-027 Defined: port ovf SHALL exist and update with diff, as ovf = (a_msb != b_msb) & (diff_msb != a_msb).
REQ-028 Undefined: port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package serial_sub_pkg SHALL hold the FSM state enum typedef and the default WIDTH constant.
REQ-030 The per-bit cell SHALL be a sub-module full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-031 Shift registers for a, b and diff plus a clog2(WIDTH)-bit counter SHALL live in the top level.

Verification
REQ-032 Scenario, WIDTH=8: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, done 9 edges after start.
REQ-033 Scenario: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; with macro, ovf=0.
REQ-034 Scenario, macro on: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-035 Scenario: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; then start held during DONE with a=0x10, b=0x01 -> diff=0x0F, with busy rising on the edge after done.
REQ-036 Scenario: start pulsed and a/b changed mid-RUN -> result unchanged, no extra done.
REQ-037 Scenario: rst_n low at RUN bit 4 -> outputs zero immediately, no done, and a new start completes normally.
